// File: rtl/clb_cfg_pkg.sv
// Shared constants for the CLB configuration loader and the CLB-side decode:
// sync pattern, configuration word width, DATA field layout, loader states.
package clb_cfg_pkg;

  localparam logic [7:0] SYNC_DEFAULT = 8'hB5;
  localparam int         CFG_WIDTH    = 37;

  // DATA field layout, LSB offsets. Every mux select is 2 bits wide, which
  // is what brings the packed word to 37 bits.
  localparam int SEL_W           = 2;
  localparam int MEM_LSB         = 0;
  localparam int MEM_W           = 16;
  localparam int FLOPORLATCH_BIT = 16;
  localparam int DQMUX2_BIT      = 17;
  localparam int DQMUX1_BIT      = 18;
  localparam int O2M3_1_BIT      = 19;
  localparam int O2M2_1_BIT      = 20;
  localparam int O2M1_1_BIT      = 21;
  localparam int O2M3_0_BIT      = 22;
  localparam int O2M2_0_BIT      = 23;
  localparam int O2M1_0_BIT      = 24;
  localparam int COMBOPTION_LSB  = 25;
  localparam int MUX6SEL_LSB     = 27;
  localparam int MUX5SEL_LSB     = 29;
  localparam int MUX4SEL_LSB     = 31;
  localparam int MUX3SEL_LSB     = 33;
  localparam int MUX2SEL_LSB     = 35;

  typedef enum logic [2:0] {
    HUNT,
    ADDR,
    DATA,
    PAR,
    WRITE,
    DONE_ST
  } cfg_state_t;

endpackage

// File: rtl/clb_cfg_shifter.sv
// Generic MSB-first shift register with enable, synchronous clear,
// accepted-bit counter and running parity of the accepted bits.
module clb_cfg_shifter #(
  parameter int W     = 45,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             din,
  output logic [W-1:0]     data,
  output logic [CNT_W-1:0] count,
  output logic             parity
);

  // Shift in one bit per enabled cycle; clear restarts a new field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data   <= '0;
      count  <= '0;
      parity <= 1'b0;
    end else if (clr) begin
      data   <= '0;
      count  <= '0;
      parity <= 1'b0;
    end else if (en) begin
      data   <= {data[W-2:0], din};
      count  <= count + 1'b1;
      parity <= parity ^ din;
    end
  end

endmodule

// File: rtl/clb_cfg_loader.sv
// Serial configuration loader: hunts for the sync pattern, deserialises
// ADDR+DATA frames, parity/range checks them and writes the CLB array.
module clb_cfg_loader
  import clb_cfg_pkg::*;
#(
  parameter int         N_CLB  = 64,
  parameter int         ADDR_W = 8,
  parameter int         CFG_W  = CFG_WIDTH,
  parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
  input  logic              K,
  input  logic              RST,
  input  logic              DIN,
  input  logic              DVALID,
  output logic [ADDR_W-1:0] CFG_ADDR,
  output logic [CFG_W-1:0]  CFG_DATA,
  output logic              CFG_WE,
  output logic              DONE,
  output logic              ERR,
  output logic [ADDR_W:0]   FRAME_CNT
);

  localparam int SH_W  = ADDR_W + CFG_W;
  localparam int CNT_W = $clog2(SH_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(SH_W - 1);
  localparam logic [ADDR_W:0]  N_CLB_C   = (ADDR_W + 1)'(N_CLB);

  cfg_state_t        state;
  logic [7:0]        window;
  logic [7:0]        window_next;
  logic              sync_hit;
  logic              sh_en;
  logic              sh_clr;
  logic [SH_W-1:0]   sh_data;
  logic [CNT_W-1:0]  sh_count;
  logic              sh_parity;
  logic              addr_ok;
  logic              par_ok;
  logic [ADDR_W:0]   cnt_next;

  // Sync detection, shifter control and frame acceptance terms.
  always_comb begin
    window_next = {window[6:0], DIN};
    sync_hit    = (window_next == SYNC);
    sh_clr      = (state == HUNT) && DVALID && sync_hit;
    sh_en       = DVALID && ((state == ADDR) || (state == DATA));
    addr_ok     = ({1'b0, sh_data[SH_W-1:CFG_W]} < N_CLB_C);
    par_ok      = ~(sh_parity ^ DIN);
    cnt_next    = FRAME_CNT + 1'b1;
  end

  clb_cfg_shifter #(
    .W     (SH_W),
    .CNT_W (CNT_W)
  ) u_shifter (
    .clk    (K),
    .rst    (RST),
    .en     (sh_en),
    .clr    (sh_clr),
    .din    (DIN),
    .data   (sh_data),
    .count  (sh_count),
    .parity (sh_parity)
  );

  // Frame FSM with registered outputs. CFG_ADDR/CFG_DATA/CFG_WE are loaded
  // on the edge that accepts a good P bit so they are valid during WRITE.
  always_ff @(posedge K or posedge RST) begin
    if (RST) begin
      state     <= HUNT;
      window    <= '0;
      CFG_ADDR  <= '0;
      CFG_DATA  <= '0;
      CFG_WE    <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      FRAME_CNT <= '0;
    end else begin
      CFG_WE <= 1'b0;
      case (state)
        HUNT: begin
          if (DVALID) begin
            if (sync_hit) begin
              window <= '0;
              state  <= ADDR;
            end else begin
              window <= window_next;
            end
          end
        end
        ADDR: begin
          if (DVALID && (sh_count == ADDR_LAST)) state <= DATA;
        end
        DATA: begin
          if (DVALID && (sh_count == DATA_LAST)) state <= PAR;
        end
        PAR: begin
          if (DVALID) begin
            if (par_ok && addr_ok) begin
              CFG_WE   <= 1'b1;
              CFG_ADDR <= sh_data[SH_W-1:CFG_W];
              CFG_DATA <= sh_data[CFG_W-1:0];
              state    <= WRITE;
            end else begin
              ERR   <= 1'b1;
              state <= HUNT;
            end
          end
        end
        WRITE: begin
          FRAME_CNT <= cnt_next;
          if (cnt_next == N_CLB_C) begin
            DONE  <= 1'b1;
            state <= DONE_ST;
          end else begin
            state <= HUNT;
          end
        end
        DONE_ST: state <= DONE_ST;
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Scoreboard bench for clb_cfg_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares on every CFG_WE.
module tb_clb_cfg_loader;

  logic        K = 1'b0;
  logic        RST;
  logic        DIN;
  logic        DVALID;
  logic [7:0]  CFG_ADDR;
  logic [36:0] CFG_DATA;
  logic        CFG_WE;
  logic        DONE;
  logic        ERR;
  logic [8:0]  FRAME_CNT;

  clb_cfg_loader #(
    .N_CLB  (64),
    .ADDR_W (8),
    .CFG_W  (37),
    .SYNC   (8'hB5)
  ) dut (
    .K         (K),
    .RST       (RST),
    .DIN       (DIN),
    .DVALID    (DVALID),
    .CFG_ADDR  (CFG_ADDR),
    .CFG_DATA  (CFG_DATA),
    .CFG_WE    (CFG_WE),
    .DONE      (DONE),
    .ERR       (ERR),
    .FRAME_CNT (FRAME_CNT)
  );

  always #5 K = ~K;

  int unsigned cyc = 0;
  always @(posedge K) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  a;
    logic [36:0] d;
    logic [8:0]  cnt;
    int unsigned sync_cyc;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [8:0]  model_cnt;
  logic        prev_we = 1'b0;
  logic [7:0]  sync_pat = 8'hB5;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge K) begin
    if (CFG_WE === 1'b1) begin
      check("we_width", 64'(prev_we), 64'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we: actual addr=%0h data=%0h required no write", CFG_ADDR, CFG_DATA);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", 64'(CFG_ADDR), 64'(mon_e.a));
        check("wr_data", 64'(CFG_DATA), 64'(mon_e.d));
        check("wr_cnt", 64'(FRAME_CNT), 64'(mon_e.cnt));
        check("wr_latency", 64'(cyc - mon_e.sync_cyc), 64'(mon_e.lat));
      end
    end
    prev_we = CFG_WE;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic bit_cycle(input logic b, input logic v);
    DIN    = b;
    DVALID = v;
    @(posedge K);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit tog);
    bit_cycle(b, 1'b1);
    if (tog) bit_cycle(~b, 1'b0);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n, input bit tog);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], tog);
  endtask

  task automatic send_sync(input bit tog, output int unsigned sc);
    sc = 0;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(sync_pat[i], 1'b1);
      if (i == 0) sc = cyc;
      if (tog) bit_cycle(~sync_pat[i], 1'b0);
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [36:0] d,
                            input bit flip, input bit tog, input bit expect_wr);
    int unsigned sc;
    exp_t        e;
    logic        p;
    send_sync(tog, sc);
    if (expect_wr) begin
      e.a        = a;
      e.d        = d;
      e.cnt      = model_cnt;
      e.sync_cyc = sc;
      e.lat      = tog ? 92 : 46;
      sb.push_back(e);
      model_cnt++;
    end
    send_bits(64'(a), 8, tog);
    send_bits(64'(d), 37, tog);
    p = (^{a, d}) ^ flip;
    send_bit(p, tog);
    if (!tog) bit_cycle(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    check("pending", 64'(sb.size()), 64'd0);
    sb.delete();
    RST    = 1'b1;
    DIN    = 1'b0;
    DVALID = 1'b0;
    @(posedge K);
    #1;
    RST       = 1'b0;
    model_cnt = '0;
  endtask

  initial begin
    int unsigned sc;
    logic [36:0] d;
    RST       = 1'b1;
    DIN       = 1'b0;
    DVALID    = 1'b0;
    model_cnt = '0;
    @(posedge K);
    #1;
    check("rst_addr", 64'(CFG_ADDR), 64'd0);
    check("rst_data", 64'(CFG_DATA), 64'd0);
    check("rst_we", 64'(CFG_WE), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);
    check("rst_err", 64'(ERR), 64'd0);
    check("rst_cnt", 64'(FRAME_CNT), 64'd0);
    RST = 1'b0;

    // One good frame: ADDR=3, mem=16'h0116, P=0
    send_frame(8'd3, 37'h0_0000_0116, 1'b0, 1'b0, 1'b1);
    check("t1_cnt", 64'(FRAME_CNT), 64'd1);
    check("t1_err", 64'(ERR), 64'd0);
    check("t1_hold_addr", 64'(CFG_ADDR), 64'd3);
    check("t1_hold_data", 64'(CFG_DATA), 64'h116);

    // Flipped parity, then a good frame is still written
    do_reset();
    send_frame(8'd3, 37'h0_0000_0116, 1'b1, 1'b0, 1'b0);
    check("t2_err", 64'(ERR), 64'd1);
    check("t2_cnt0", 64'(FRAME_CNT), 64'd0);
    send_frame(8'd9, 37'h1F_0000_ABCD, 1'b0, 1'b0, 1'b1);
    check("t2_cnt1", 64'(FRAME_CNT), 64'd1);
    check("t2_err_sticky", 64'(ERR), 64'd1);

    // Out-of-range address with correct parity
    do_reset();
    send_frame(8'd64, 37'h0_0000_0116, 1'b0, 1'b0, 1'b0);
    check("t3_err", 64'(ERR), 64'd1);
    check("t3_cnt", 64'(FRAME_CNT), 64'd0);

    // DVALID toggling every cycle
    do_reset();
    send_frame(8'd3, 37'h0_0000_0116, 1'b0, 1'b1, 1'b1);
    check("t4_cnt", 64'(FRAME_CNT), 64'd1);
    check("t4_data", 64'(CFG_DATA), 64'h116);

    // All 64 addresses, then DONE, then further frames ignored
    do_reset();
    for (int unsigned i = 0; i < 64; i++) begin
      d = {5'(i), 32'hA5C3_0000 | 32'(i)};
      send_frame(8'(i), d, 1'b0, 1'b0, 1'b1);
      if (i == 62) begin
        check("t5_done_early", 64'(DONE), 64'd0);
        check("t5_cnt63", 64'(FRAME_CNT), 64'd63);
      end
    end
    check("t5_done", 64'(DONE), 64'd1);
    check("t5_cnt64", 64'(FRAME_CNT), 64'd64);
    send_frame(8'd5, 37'h0_0000_0116, 1'b0, 1'b0, 1'b0);
    check("t5_cnt_after", 64'(FRAME_CNT), 64'd64);
    check("t5_done_sticky", 64'(DONE), 64'd1);

    // Reset in the middle of DATA
    do_reset();
    send_frame(8'd7, 37'h1A_BCDE_F012, 1'b0, 1'b0, 1'b1);
    check("t6_pre_pending", 64'(sb.size()), 64'd0);
    send_sync(1'b0, sc);
    send_bits(64'd12, 8, 1'b0);
    send_bits(64'(37'h0_1234_5678 >> 17), 20, 1'b0);
    RST = 1'b1;
    #1;
    check("t6_async_addr", 64'(CFG_ADDR), 64'd0);
    check("t6_async_data", 64'(CFG_DATA), 64'd0);
    check("t6_async_cnt", 64'(FRAME_CNT), 64'd0);
    check("t6_async_we", 64'(CFG_WE), 64'd0);
    @(posedge K);
    #1;
    RST       = 1'b0;
    model_cnt = '0;
    send_frame(8'd12, 37'h0_1234_5678, 1'b0, 1'b0, 1'b1);
    check("t6_cnt", 64'(FRAME_CNT), 64'd1);
    check("t6_addr", 64'(CFG_ADDR), 64'd12);
    check("t6_data", 64'(CFG_DATA), 64'h0_1234_5678);
    check("t6_err", 64'(ERR), 64'd0);

    repeat (3) bit_cycle(1'b0, 1'b0);
    check("final_pending", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
